// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - access codes, FSM states and UART status address for mem_access_ctrl
package mem_pkg;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_RAM  = 2'b01;
  localparam logic [1:0] MEM_UART = 2'b10;

  localparam logic [15:0] UART_STATUS_ADDR = 16'hBF01;

  typedef enum logic [2:0] {
    IDLE,
    RAM_ACC,
    RX_WAIT,
    RX_RD,
    TX_WAIT,
    TX_WR,
    DONE
  } accState_t;

  // Code 11 is reserved and treated the same as "no access".
  function automatic logic isReq(input logic [1:0] code);
    return (code == MEM_RAM) || (code == MEM_UART);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_bus_driver.sv
// rtl/mem_access_ctrl_bus_driver.sv - tri-state driver for the shared SRAM/UART data bus
module bus_driver (
  input  logic        en,
  input  logic [15:0] data,
  inout  wire  [15:0] bus
);

  assign bus = en ? data : 16'hzzzz;

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage controller sequencing SRAM and UART accesses with pipeline stall
// Optional: define UART_STATUS_EN to serve UART status reads at UART_STATUS_ADDR without strobes.
module mem_access_ctrl #(
  parameter int RAM_WAIT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [1:0]  memReadIn,
  input  logic [1:0]  memWriteIn,
  input  logic [15:0] addrIn,
  input  logic [15:0] wdataIn,
  output logic        stallOut,
  output logic [15:0] rdataOut,
  output logic        rdataValidOut,
  output logic [15:0] ramAddrOut,
  output logic        ramEnN,
  output logic        ramOeN,
  output logic        ramWeN,
  inout  wire  [15:0] dataBus,
  output logic        uartRdN,
  output logic        uartWrN,
  input  logic        uartDataReady,
  input  logic        uartTbre,
  input  logic        uartTsre
);
  import mem_pkg::*;

  accState_t   state;
  logic [3:0]  waitCnt;
  logic        isRead;
  logic [15:0] wdataReg;
  logic        busEn;
  logic        writeReq;
  logic        readReq;
  logic        statusHit;

  assign writeReq = isReq(memWriteIn);
  assign readReq  = isReq(memReadIn);

`ifdef UART_STATUS_EN
  assign statusHit = (addrIn == UART_STATUS_ADDR);
`else
  assign statusHit = 1'b0;
`endif

  // Stall is forced low during reset so a pending request cannot freeze the pipeline.
  assign stallOut = RST_N && (((state == IDLE) && (writeReq || readReq)) ||
                              ((state != IDLE) && (state != DONE)));

  bus_driver u_busDriver (
    .en   (busEn),
    .data (wdataReg),
    .bus  (dataBus)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= IDLE;
      waitCnt       <= '0;
      isRead        <= 1'b0;
      wdataReg      <= '0;
      busEn         <= 1'b0;
      rdataOut      <= '0;
      rdataValidOut <= 1'b0;
      ramAddrOut    <= '0;
      ramEnN        <= 1'b1;
      ramOeN        <= 1'b1;
      ramWeN        <= 1'b1;
      uartRdN       <= 1'b1;
      uartWrN       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          rdataValidOut <= 1'b0;
          // Write wins over a simultaneous read; the read is simply dropped.
          if (writeReq) begin
            isRead   <= 1'b0;
            wdataReg <= wdataIn;
            if (memWriteIn == MEM_RAM) begin
              state      <= RAM_ACC;
              waitCnt    <= 4'(RAM_WAIT_CYCLES - 1);
              ramAddrOut <= addrIn;
              ramEnN     <= 1'b0;
              ramWeN     <= 1'b0;
              busEn      <= 1'b1;
            end else begin
              state <= TX_WAIT;
            end
          end else if (readReq) begin
            isRead <= 1'b1;
            if (memReadIn == MEM_RAM) begin
              state      <= RAM_ACC;
              waitCnt    <= 4'(RAM_WAIT_CYCLES - 1);
              ramAddrOut <= addrIn;
              ramEnN     <= 1'b0;
              ramOeN     <= 1'b0;
            end else if (statusHit) begin
              state         <= DONE;
              rdataOut      <= {14'b0, uartDataReady, uartTbre & uartTsre};
              rdataValidOut <= 1'b1;
            end else begin
              state <= RX_WAIT;
            end
          end
        end
        RAM_ACC: begin
          if (waitCnt == 4'd0) begin
            state  <= DONE;
            ramEnN <= 1'b1;
            ramOeN <= 1'b1;
            ramWeN <= 1'b1;
            busEn  <= 1'b0;
            if (isRead) begin
              rdataOut      <= dataBus;
              rdataValidOut <= 1'b1;
            end
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end
        RX_WAIT: begin
          if (uartDataReady) begin
            state   <= RX_RD;
            uartRdN <= 1'b0;
          end
        end
        RX_RD: begin
          state         <= DONE;
          uartRdN       <= 1'b1;
          rdataOut      <= dataBus;
          rdataValidOut <= 1'b1;
        end
        TX_WAIT: begin
          if (uartTbre && uartTsre) begin
            state   <= TX_WR;
            uartWrN <= 1'b0;
            busEn   <= 1'b1;
          end
        end
        TX_WR: begin
          state   <= DONE;
          uartWrN <= 1'b1;
          busEn   <= 1'b0;
        end
        DONE: begin
          state         <= IDLE;
          rdataValidOut <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [1:0]  memReadIn, memWriteIn;
  logic [15:0] addrIn, wdataIn;
  logic        stallOut, rdataValidOut;
  logic [15:0] rdataOut, ramAddrOut;
  logic        ramEnN, ramOeN, ramWeN, uartRdN, uartWrN;
  logic        uartDataReady, uartTbre, uartTsre;
  logic        tbEn;
  logic [15:0] tbData;
  wire  [15:0] dataBus;

  int errors = 0;
  int checks = 0;

  // Stands in for the SRAM/UART side of the shared bus.
  assign dataBus = tbEn ? tbData : 16'hzzzz;

  always #5 CLK = ~CLK;

  mem_access_ctrl #(.RAM_WAIT_CYCLES(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .memReadIn(memReadIn), .memWriteIn(memWriteIn),
    .addrIn(addrIn), .wdataIn(wdataIn), .stallOut(stallOut), .rdataOut(rdataOut),
    .rdataValidOut(rdataValidOut), .ramAddrOut(ramAddrOut), .ramEnN(ramEnN),
    .ramOeN(ramOeN), .ramWeN(ramWeN), .dataBus(dataBus), .uartRdN(uartRdN),
    .uartWrN(uartWrN), .uartDataReady(uartDataReady), .uartTbre(uartTbre),
    .uartTsre(uartTsre)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge CLK);
    #1 memReadIn = 2'b01;
    #1;
    checks++; if (stallOut !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=0", stallOut); end
    checks++; if ({ramEnN, ramOeN, ramWeN, uartRdN, uartWrN} !== 5'b11111) begin errors++; $display("FAIL rst_strobes got=%b exp=11111", {ramEnN, ramOeN, ramWeN, uartRdN, uartWrN}); end
    checks++; if (rdataOut !== 16'h0000) begin errors++; $display("FAIL rst_rdata got=%h exp=0000", rdataOut); end
    checks++; if (rdataValidOut !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", rdataValidOut); end
    checks++; if (ramAddrOut !== 16'h0000) begin errors++; $display("FAIL rst_addr got=%h exp=0000", ramAddrOut); end
    memReadIn = 2'b00;
    RST_N = 1'b1;
    tick();
    checks++; if (stallOut !== 1'b0) begin errors++; $display("FAIL idle_stall got=%b exp=0", stallOut); end
  endtask

  task automatic test_ram_read();
    tbEn = 1'b1; tbData = 16'h1234;
    memReadIn = 2'b01; addrIn = 16'h0040;
    #1;
    checks++; if (stallOut !== 1'b1) begin errors++; $display("FAIL rd_stall_idle got=%b exp=1", stallOut); end
    tick();
    memReadIn = 2'b00; addrIn = 16'h7777;
    #1;
    checks++; if ({ramEnN, ramOeN, ramWeN} !== 3'b001) begin errors++; $display("FAIL rd_strobes got=%b exp=001", {ramEnN, ramOeN, ramWeN}); end
    checks++; if (ramAddrOut !== 16'h0040) begin errors++; $display("FAIL rd_addr got=%h exp=0040", ramAddrOut); end
    checks++; if (stallOut !== 1'b1) begin errors++; $display("FAIL rd_stall_acc got=%b exp=1", stallOut); end
    tick();
    checks++; if ({ramEnN, ramOeN} !== 2'b11) begin errors++; $display("FAIL rd_release got=%b exp=11", {ramEnN, ramOeN}); end
    checks++; if (stallOut !== 1'b0) begin errors++; $display("FAIL rd_stall_done got=%b exp=0", stallOut); end
    checks++; if (rdataValidOut !== 1'b1) begin errors++; $display("FAIL rd_valid got=%b exp=1", rdataValidOut); end
    checks++; if (rdataOut !== 16'h1234) begin errors++; $display("FAIL rd_data got=%h exp=1234", rdataOut); end
    tick();
    checks++; if (rdataValidOut !== 1'b0) begin errors++; $display("FAIL rd_valid_end got=%b exp=0", rdataValidOut); end
    tbEn = 1'b0;
  endtask

  task automatic test_ram_write();
    memWriteIn = 2'b01; addrIn = 16'h0041; wdataIn = 16'hBEEF;
    tick();
    memWriteIn = 2'b00; wdataIn = 16'h0000;
    #1;
    checks++; if ({ramEnN, ramOeN, ramWeN} !== 3'b010) begin errors++; $display("FAIL wr_strobes got=%b exp=010", {ramEnN, ramOeN, ramWeN}); end
    checks++; if (dataBus !== 16'hBEEF) begin errors++; $display("FAIL wr_bus got=%h exp=beef", dataBus); end
    checks++; if (ramAddrOut !== 16'h0041) begin errors++; $display("FAIL wr_addr got=%h exp=0041", ramAddrOut); end
    tick();
    checks++; if (ramWeN !== 1'b1) begin errors++; $display("FAIL wr_we_done got=%b exp=1", ramWeN); end
    checks++; if (rdataValidOut !== 1'b0) begin errors++; $display("FAIL wr_valid got=%b exp=0", rdataValidOut); end
    tbEn = 1'b1; tbData = 16'h5A5A;
    #1;
    checks++; if (dataBus !== 16'h5A5A) begin errors++; $display("FAIL wr_bus_release got=%h exp=5a5a", dataBus); end
    tbEn = 1'b0;
    tick();
  endtask

  task automatic test_uart_write();
    uartTbre = 1'b0; uartTsre = 1'b1;
    memWriteIn = 2'b10; wdataIn = 16'hC0DE; addrIn = 16'hBF00;
    tick();
    memWriteIn = 2'b00; wdataIn = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if ({stallOut, uartWrN} !== 2'b11) begin errors++; $display("FAIL tx_wait[%0d] stall_wrn got=%b exp=11", i, {stallOut, uartWrN}); end
      tick();
    end
    uartTbre = 1'b1;
    tick();
    checks++; if (uartWrN !== 1'b0) begin errors++; $display("FAIL tx_wrn got=%b exp=0", uartWrN); end
    checks++; if (dataBus !== 16'hC0DE) begin errors++; $display("FAIL tx_bus got=%h exp=c0de", dataBus); end
    checks++; if ({ramEnN, ramWeN, stallOut} !== 3'b111) begin errors++; $display("FAIL tx_ram_stall got=%b exp=111", {ramEnN, ramWeN, stallOut}); end
    tick();
    checks++; if ({uartWrN, stallOut, rdataValidOut} !== 3'b100) begin errors++; $display("FAIL tx_done got=%b exp=100", {uartWrN, stallOut, rdataValidOut}); end
    tick();
  endtask

  task automatic test_uart_read(input logic [15:0] addr);
    uartDataReady = 1'b0; tbEn = 1'b1; tbData = 16'h00A5;
    memReadIn = 2'b10; addrIn = addr;
    tick();
    memReadIn = 2'b00;
    #1;
    checks++; if ({stallOut, uartRdN} !== 2'b11) begin errors++; $display("FAIL rx_wait got=%b exp=11", {stallOut, uartRdN}); end
    tick();
    uartDataReady = 1'b1;
    tick();
    uartDataReady = 1'b0;
    checks++; if ({uartRdN, stallOut, ramEnN} !== 3'b011) begin errors++; $display("FAIL rx_rd got=%b exp=011", {uartRdN, stallOut, ramEnN}); end
    tick();
    checks++; if (rdataOut !== 16'h00A5) begin errors++; $display("FAIL rx_data got=%h exp=00a5", rdataOut); end
    checks++; if ({rdataValidOut, uartRdN, stallOut} !== 3'b110) begin errors++; $display("FAIL rx_done got=%b exp=110", {rdataValidOut, uartRdN, stallOut}); end
    tick();
    tbEn = 1'b0;
  endtask

  task automatic test_write_wins();
    tbEn = 1'b0;
    memReadIn = 2'b10; memWriteIn = 2'b01; addrIn = 16'h0050; wdataIn = 16'h4321;
    tick();
    memReadIn = 2'b00; memWriteIn = 2'b00;
    checks++; if ({ramWeN, ramOeN, uartRdN, uartWrN} !== 4'b0111) begin errors++; $display("FAIL ww_strobes got=%b exp=0111", {ramWeN, ramOeN, uartRdN, uartWrN}); end
    checks++; if (dataBus !== 16'h4321) begin errors++; $display("FAIL ww_bus got=%h exp=4321", dataBus); end
    tick();
    checks++; if ({rdataValidOut, uartRdN, stallOut} !== 3'b010) begin errors++; $display("FAIL ww_done got=%b exp=010", {rdataValidOut, uartRdN, stallOut}); end
    tick();
    checks++; if (uartRdN !== 1'b1) begin errors++; $display("FAIL ww_no_rx got=%b exp=1", uartRdN); end
  endtask

  task automatic test_reset_mid_access();
    memWriteIn = 2'b01; addrIn = 16'h0060; wdataIn = 16'h1111;
    tick();
    memWriteIn = 2'b00;
    checks++; if (ramWeN !== 1'b0) begin errors++; $display("FAIL rm_we_pre got=%b exp=0", ramWeN); end
    RST_N = 1'b0;
    #1;
    checks++; if ({ramEnN, ramOeN, ramWeN, stallOut} !== 4'b1110) begin errors++; $display("FAIL rm_abort got=%b exp=1110", {ramEnN, ramOeN, ramWeN, stallOut}); end
    tbEn = 1'b1; tbData = 16'h5A5A;
    #1;
    checks++; if (dataBus !== 16'h5A5A) begin errors++; $display("FAIL rm_bus_release got=%h exp=5a5a", dataBus); end
    tbEn = 1'b0;
    RST_N = 1'b1;
    tick();
    checks++; if ({rdataValidOut, ramWeN, stallOut} !== 3'b010) begin errors++; $display("FAIL rm_after got=%b exp=010", {rdataValidOut, ramWeN, stallOut}); end
    tick();
    checks++; if (rdataValidOut !== 1'b0) begin errors++; $display("FAIL rm_no_pulse got=%b exp=0", rdataValidOut); end
  endtask

`ifdef UART_STATUS_EN
  task automatic test_uart_status();
    uartDataReady = 1'b1; uartTbre = 1'b1; uartTsre = 1'b1;
    memReadIn = 2'b10; addrIn = 16'hBF01;
    #1;
    checks++; if (stallOut !== 1'b1) begin errors++; $display("FAIL st_stall got=%b exp=1", stallOut); end
    tick();
    memReadIn = 2'b00; uartDataReady = 1'b0;
    checks++; if (rdataOut !== 16'h0003) begin errors++; $display("FAIL st_data got=%h exp=0003", rdataOut); end
    checks++; if ({rdataValidOut, uartRdN, stallOut} !== 3'b110) begin errors++; $display("FAIL st_done got=%b exp=110", {rdataValidOut, uartRdN, stallOut}); end
    tick();
  endtask
`endif

  initial begin
    RST_N = 1'b0;
    memReadIn = 2'b00; memWriteIn = 2'b00;
    addrIn = 16'h0000; wdataIn = 16'h0000;
    uartDataReady = 1'b0; uartTbre = 1'b1; uartTsre = 1'b1;
    tbEn = 1'b0; tbData = 16'h0000;
    test_reset();
    test_ram_read();
    test_ram_write();
    test_uart_write();
`ifdef UART_STATUS_EN
    test_uart_read(16'hBF00);
    test_uart_status();
`else
    test_uart_read(16'hBF01);
`endif
    test_write_wins();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter RAM_WAIT_CYCLES, default 1: cycles the SRAM strobes are held low per access (legal range 1..15).
REQ-002 SHALL have port CLK  in  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST_N  in  1: asynchronous, active-low reset.
REQ-004 SHALL have port memReadIn  in  2: read request code from the EX/MEM register (00 none, 01 RAM, 10 UART, 11 none).
REQ-005 SHALL have port memWriteIn  in  2: write request code, same encoding as memReadIn.
REQ-006 SHALL have port addrIn  in  16: access address (ALU result).
REQ-007 SHALL have port wdataIn  in  16: store data.
REQ-008 SHALL have port stallOut  out  1: freeze the IF/ID/EX/EX_MEM pipeline registers while high.
REQ-009 SHALL have port rdataOut  out  16: registered load data for MEM/WB.
REQ-010 SHALL have port rdataValidOut  out  1: one-cycle pulse, rdataOut valid.
REQ-011 SHALL have ports ramAddrOut  out  16, ramEnN / ramOeN / ramWeN  out  1 each: SRAM address and active-low strobes.
REQ-012 SHALL have port dataBus  inout  16: data bus shared by SRAM and UART, driven only during writes.
REQ-013 SHALL have ports uartRdN / uartWrN  out  1 each; uartDataReady, uartTbre, uartTsre  in  1 each.

Function
REQ-014 SHALL implement the states IDLE, RAM_ACC, RX_WAIT, RX_RD, TX_WAIT, TX_WR and DONE.
REQ-015 In IDLE with no request (both codes 00/11), SHALL keep stallOut=0 and all strobes high.
REQ-016 A request SHALL be a non-zero, non-11 code; if read and write are both requested, write SHALL win and the read SHALL be dropped.
REQ-017 stallOut SHALL be combinational: 1 in IDLE when a request is present, 1 in every state except IDLE and DONE, and 0 in DONE.
REQ-018 On a RAM request, SHALL enter RAM_ACC for exactly RAM_WAIT_CYCLES cycles with ramEnN=0 and ramAddrOut=addrIn.
REQ-019 During a RAM read, ramOeN SHALL be 0 and dataBus SHALL be undriven; dataBus SHALL be captured into rdataOut on the final RAM_ACC cycle.
REQ-020 During a RAM write, ramWeN SHALL be 0 and dataBus SHALL be driven with wdataIn.
REQ-021 On a UART read, SHALL wait in RX_WAIT until uartDataReady=1, then spend one cycle in RX_RD with uartRdN=0, capture dataBus, then enter DONE.
REQ-022 On a UART write, SHALL wait in TX_WAIT until uartTbre&uartTsre=1, then spend one cycle in TX_WR with uartWrN=0 and dataBus=wdataIn, then enter DONE.
REQ-023 DONE SHALL last one cycle, pulse rdataValidOut=1 for reads only, and return to IDLE.
REQ-024 Total latency SHALL be RAM_WAIT_CYCLES+2 cycles for RAM accesses, and wait time+3 cycles for UART accesses.
REQ-025 RAM and UART strobes SHALL never be low in the same cycle; dataBus SHALL be undriven in the cycle after any write strobe.
REQ-026 The request SHALL be sampled only in IDLE; input changes mid-access SHALL be ignored.

Reset
REQ-027 While RST_N=0, SHALL force state=IDLE, rdataOut=0, rdataValidOut=0, stallOut=0, all strobes=1, dataBus undriven and ramAddrOut=0, asynchronously.
REQ-028 Reset asserted mid-access SHALL abort the access immediately, with no completion pulse.

Configuration
REQ-029 With macro UART_STATUS_EN defined, a UART read at addrIn=16'hBF01 SHALL skip the strobes and go IDLE->DONE, returning {14'b0, uartDataReady, uartTbre&uartTsre} with 1-cycle stall.
REQ-030 Without UART_STATUS_EN, address 16'hBF01 SHALL be treated as an ordinary UART data read.

Structure
REQ-031 A shared package mem_pkg SHALL hold the access-code constants (MEM_NONE, MEM_RAM, MEM_UART), the state enum and the UART_STATUS_ADDR constant.
REQ-032 The tri-state dataBus driver SHALL be one sub-module, bus_driver (enable plus 16-bit data).

Verification
REQ-033 RAM read, RAM_WAIT_CYCLES=1, addrIn=0x0040, bus=0x1234 -> ramOeN low for 1 cycle, stall for 2 cycles, rdataOut=0x1234 with a valid pulse in DONE.
REQ-034 RAM write, addr 0x0041, wdata 0xBEEF -> ramWeN low for 1 cycle with bus=0xBEEF, no valid pulse, bus released the next cycle.
REQ-035 UART write with uartTbre=0 for 5 cycles -> stall held for 5 cycles in TX_WAIT, then one uartWrN-low cycle with bus=wdataIn, then DONE.
REQ-036 UART read with memRead=10 and memWrite=01 together -> the RAM write executes and no UART strobe occurs.
REQ-037 RST_N pulsed low mid-RAM_ACC -> strobes high and bus released in the same cycle, state IDLE, no valid pulse.
REQ-038 UART_STATUS_EN defined, read at 0xBF01 with uartDataReady=1, uartTbre=1, uartTsre=1 -> rdataOut=0x0003 after 1 stall cycle, no uartRdN pulse.
